// File: rtl/eth_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_seq_pkg
// Description : Shared types and constants for the Ethernet cycle sequencer.
//               Provides the sequencer state encoding, the access direction
//               type, default setup/strobe/hold lengths and a helper that
//               sizes the phase down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_t;

    localparam int c_def_setup_cyc  = 1;
    localparam int c_def_strobe_cyc = 3;
    localparam int c_def_hold_cyc   = 1;

    // Width needed to hold values 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_cycle_sequencer_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchroniser for a single asynchronous level.
//               Both flops reset asynchronously to RESET_VAL.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input level
//               q     - synchronised level, two clk after d
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/eth_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : eth_cycle_sequencer
// Description : Sequences host (IOC) accesses to the external Ethernet chip
//               with programmable setup / strobe / hold timing on clk and
//               stretches the host cycle through IOGT until the access is
//               complete. Owns the 8-bit Ethernet data path.
// Build option: ETH_WRITE_POST_EN - writes are posted: IOGT is not dropped
//               for a write; a new host access arriving while a posted write
//               is still running is stretched until it can start.
// Ports       : clk, nRST            - clock, async active-low reset
//               sel, nRE, nWE, A9    - host decode/strobes (async) and address
//               host_d_in/host_d_out - host write data / registered read data
//               eth_d_in/eth_d_out   - chip read data / chip write data
//               eth_d_oe             - output enable for eth_d_out
//               nETH_CS, ETH_CMD, nETH_RE, nETH_WE - chip control
//               IOGT                 - host grant, low stretches the host
//               busy                 - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module eth_cycle_sequencer
    import eth_seq_pkg::*;
#(
    parameter int SETUP_CYC  = c_def_setup_cyc,
    parameter int STROBE_CYC = c_def_strobe_cyc,
    parameter int HOLD_CYC   = c_def_hold_cyc
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       sel,
    input  logic       nRE,
    input  logic       nWE,
    input  logic       A9,
    input  logic [7:0] host_d_in,
    output logic [7:0] host_d_out,
    input  logic [7:0] eth_d_in,
    output logic [7:0] eth_d_out,
    output logic       eth_d_oe,
    output logic       nETH_CS,
    output logic       ETH_CMD,
    output logic       nETH_RE,
    output logic       nETH_WE,
    output logic       IOGT,
    output logic       busy
);

    localparam int                 c_cnt_w     = cnt_width(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC));
    localparam logic [c_cnt_w-1:0] c_setup_ld  = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_strobe_ld = c_cnt_w'(STROBE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hold_ld   = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero  = '0;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic w_sel_s;
    logic w_re_s;
    logic w_we_s;

    sync2 #(.RESET_VAL(1'b0)) u_sync_sel (.clk(clk), .rst_n(nRST), .d(sel), .q(w_sel_s));
    sync2 #(.RESET_VAL(1'b1)) u_sync_re  (.clk(clk), .rst_n(nRST), .d(nRE), .q(w_re_s));
    sync2 #(.RESET_VAL(1'b1)) u_sync_we  (.clk(clk), .rst_n(nRST), .d(nWE), .q(w_we_s));

    // A valid request needs exactly one strobe low.
    logic w_req;
    assign w_req = w_sel_s & (w_re_s ^ w_we_s);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             r_state, w_state;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt;
    dir_t               r_dir,   w_dir;
    logic               r_cs_n,  w_cs_n;
    logic               r_re_n,  w_re_n;
    logic               r_we_n,  w_we_n;
    logic               r_cmd,   w_cmd;
    logic               r_oe,    w_oe;
    logic [7:0]         r_edout, w_edout;
    logic [7:0]         r_hdout, w_hdout;
    logic               r_iogt,  w_iogt;
    logic               r_busy;

`ifdef ETH_WRITE_POST_EN
    // Set once the host has let go of sel during the current cycle, so a
    // later sel_s request is recognised as a new access rather than the
    // tail of the posted write.
    logic r_released, w_released;
    logic w_new_req;
    assign w_new_req = r_released & w_req;
`endif

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_dir   = r_dir;
        w_cs_n  = r_cs_n;
        w_re_n  = r_re_n;
        w_we_n  = r_we_n;
        w_cmd   = r_cmd;
        w_oe    = r_oe;
        w_edout = r_edout;
        w_hdout = r_hdout;
        w_iogt  = r_iogt;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state = ST_SETUP;
                    w_cnt   = c_setup_ld;
                    w_dir   = w_re_s ? DIR_WRITE : DIR_READ;
                    w_cs_n  = 1'b0;
                    w_cmd   = A9;
                    w_iogt  = 1'b0;
                    if (w_re_s) begin
                        w_edout = host_d_in;
                        w_oe    = 1'b1;
`ifdef ETH_WRITE_POST_EN
                        w_iogt  = 1'b1;
`endif
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == c_cnt_zero) begin
                    w_state = ST_STROBE;
                    w_cnt   = c_strobe_ld;
                    if (r_dir == DIR_READ) begin
                        w_re_n = 1'b0;
                    end else begin
                        w_we_n = 1'b0;
                    end
                end else begin
                    w_cnt = r_cnt - c_cnt_one;
                end
            end
            ST_STROBE: begin
                if (r_cnt == c_cnt_zero) begin
                    w_state = ST_HOLD;
                    w_cnt   = c_hold_ld;
                    w_re_n  = 1'b1;
                    w_we_n  = 1'b1;
                    // Capture on the strobe's rising edge, while the chip
                    // still drives valid data.
                    if (r_dir == DIR_READ) begin
                        w_hdout = eth_d_in;
                    end
                end else begin
                    w_cnt = r_cnt - c_cnt_one;
                end
            end
            ST_HOLD: begin
                if (r_cnt == c_cnt_zero) begin
                    w_state = ST_DONE;
                    w_cnt   = c_cnt_zero;
                    w_cs_n  = 1'b1;
                    w_oe    = 1'b0;
                    w_iogt  = 1'b1;
                end else begin
                    w_cnt = r_cnt - c_cnt_one;
                end
            end
            ST_DONE: begin
                // Wait for the host to end its cycle so one host access
                // produces exactly one chip access.
                if (!w_sel_s) begin
                    w_state = ST_IDLE;
                end
`ifdef ETH_WRITE_POST_EN
                if ((r_dir == DIR_WRITE) && r_released) begin
                    w_state = ST_IDLE;
                end
`endif
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = c_cnt_zero;
            end
        endcase

`ifdef ETH_WRITE_POST_EN
        // A new access during a posted write is held off until the
        // sequencer has returned to IDLE.
        if ((r_state != ST_IDLE) && (r_dir == DIR_WRITE) && w_new_req) begin
            w_iogt = 1'b0;
        end
`endif
    end

`ifdef ETH_WRITE_POST_EN
    always_comb begin
        w_released = r_released;
        if (r_state == ST_IDLE) begin
            w_released = 1'b0;
        end else if (!w_sel_s) begin
            w_released = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_released <= 1'b0;
        end else begin
            r_released <= w_released;
        end
    end
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_cnt   <= c_cnt_zero;
            r_dir   <= DIR_WRITE;
            r_cs_n  <= 1'b1;
            r_re_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_cmd   <= 1'b0;
            r_oe    <= 1'b0;
            r_edout <= 8'h00;
            r_hdout <= 8'h00;
            r_iogt  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_dir   <= w_dir;
            r_cs_n  <= w_cs_n;
            r_re_n  <= w_re_n;
            r_we_n  <= w_we_n;
            r_cmd   <= w_cmd;
            r_oe    <= w_oe;
            r_edout <= w_edout;
            r_hdout <= w_hdout;
            r_iogt  <= w_iogt;
            r_busy  <= (w_state != ST_IDLE);
        end
    end

    assign nETH_CS    = r_cs_n;
    assign nETH_RE    = r_re_n;
    assign nETH_WE    = r_we_n;
    assign ETH_CMD    = r_cmd;
    assign eth_d_oe   = r_oe;
    assign eth_d_out  = r_edout;
    assign host_d_out = r_hdout;
    assign IOGT       = r_iogt;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_eth_cycle_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eth_cycle_sequencer
// Description : Self-checking bench for eth_cycle_sequencer. Instance 0 uses
//               default timing (1/3/1), instance 1 uses 2/4/2. Each issued
//               access pushes its expected chip-cycle record into a queue; a
//               monitor measures every chip cycle (nETH_CS low window) and
//               compares it against the popped record.
// Build option: ETH_WRITE_POST_EN - switches write IOGT expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_cycle_sequencer;

`ifdef ETH_WRITE_POST_EN
    localparam bit c_post = 1'b1;
`else
    localparam bit c_post = 1'b0;
`endif

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic            nRST;
    logic [1:0]      sel, nre, nwe, a9;
    logic [1:0][7:0] hdin, edin;
    logic [1:0][7:0] hdout, edout;
    logic [1:0]      doe, cs_n, cmd, re_n, we_n, iogt, busy;

    eth_cycle_sequencer u_dut0 (
        .clk(clk), .nRST(nRST), .sel(sel[0]), .nRE(nre[0]), .nWE(nwe[0]), .A9(a9[0]),
        .host_d_in(hdin[0]), .host_d_out(hdout[0]), .eth_d_in(edin[0]), .eth_d_out(edout[0]),
        .eth_d_oe(doe[0]), .nETH_CS(cs_n[0]), .ETH_CMD(cmd[0]), .nETH_RE(re_n[0]),
        .nETH_WE(we_n[0]), .IOGT(iogt[0]), .busy(busy[0])
    );

    eth_cycle_sequencer #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .nRST(nRST), .sel(sel[1]), .nRE(nre[1]), .nWE(nwe[1]), .A9(a9[1]),
        .host_d_in(hdin[1]), .host_d_out(hdout[1]), .eth_d_in(edin[1]), .eth_d_out(edout[1]),
        .eth_d_oe(doe[1]), .nETH_CS(cs_n[1]), .ETH_CMD(cmd[1]), .nETH_RE(re_n[1]),
        .nETH_WE(we_n[1]), .IOGT(iogt[1]), .busy(busy[1])
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    // A negative expected value marks a field as don't-care.
    task automatic chk(input string name, input int act, input int exp);
        if (exp >= 0) begin
            n_chk++;
            if (act != exp) begin
                n_err++;
                $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                         name, act, act, exp, exp, $time);
            end
        end
    endtask

    typedef struct {
        int cmd;
        int rd;
        int cs;
        int stb;
        int setup;
        int oe;
        int iogt;
        int data;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];

    function automatic rec_t mk(input int c, input int r, input int cs, input int stb,
                                input int su, input int oe, input int io, input int d);
        rec_t x;
        x.cmd = c; x.rd = r; x.cs = cs; x.stb = stb;
        x.setup = su; x.oe = oe; x.iogt = io; x.data = d;
        return x;
    endfunction

    task automatic push(input int i, input rec_t x);
        if (i == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // ------------------------------------------------------------------
    // Monitor: measures each nETH_CS low window per instance
    // ------------------------------------------------------------------
    int m_cs[2], m_stb[2], m_setup[2], m_oe[2], m_iogt[2], m_rd[2], m_cmd[2];
    logic m_prev[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cs[i] = 0; m_stb[i] = 0; m_setup[i] = 0; m_oe[i] = 0;
            m_iogt[i] = 0; m_rd[i] = 0; m_cmd[i] = 0; m_prev[i] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!nRST) begin
                m_cs[i] = 0; m_stb[i] = 0; m_setup[i] = 0; m_oe[i] = 0;
                m_iogt[i] = 0; m_rd[i] = 0; m_prev[i] = 1'b1;
            end else begin
                if (!cs_n[i]) begin
                    m_cs[i]++;
                    if (!re_n[i] || !we_n[i]) begin
                        m_stb[i]++;
                        if (!re_n[i]) m_rd[i] = 1;
                    end else if (m_stb[i] == 0) begin
                        m_setup[i]++;
                    end
                    if (doe[i])   m_oe[i]++;
                    if (!iogt[i]) m_iogt[i]++;
                    m_cmd[i] = int'(cmd[i]);
                end else if (!m_prev[i]) begin
                    rec_t e;
                    int   have;
                    have = (i == 0) ? q0.size() : q1.size();
                    chk($sformatf("i%0d_expected_access", i), (have > 0) ? 1 : 0, 1);
                    if (have > 0) begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("i%0d_cmd", i),       m_cmd[i],   e.cmd);
                        chk($sformatf("i%0d_dir_read", i),  m_rd[i],    e.rd);
                        chk($sformatf("i%0d_cs_low", i),    m_cs[i],    e.cs);
                        chk($sformatf("i%0d_strobe", i),    m_stb[i],   e.stb);
                        chk($sformatf("i%0d_setup", i),     m_setup[i], e.setup);
                        chk($sformatf("i%0d_oe_cycles", i), m_oe[i],    e.oe);
                        chk($sformatf("i%0d_iogt_low", i),  m_iogt[i],  e.iogt);
                        chk($sformatf("i%0d_data", i),
                            m_rd[i] ? int'(hdout[i]) : int'(edout[i]), e.data);
                    end
                    m_cs[i] = 0; m_stb[i] = 0; m_setup[i] = 0;
                    m_oe[i] = 0; m_iogt[i] = 0; m_rd[i] = 0;
                end
                m_prev[i] = cs_n[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Host-side helpers
    // ------------------------------------------------------------------
    task automatic wait_iogt_high(input int i);
        for (int k = 0; k < 100 && !iogt[i]; k++) @(negedge clk);
        chk($sformatf("i%0d_iogt_release", i), int'(iogt[i]), 1);
    endtask

    task automatic wait_re_low(input int i);
        for (int k = 0; k < 100 && re_n[i]; k++) @(negedge clk);
        chk($sformatf("i%0d_strobe_seen", i), int'(re_n[i]), 0);
    endtask

    task automatic host_access(input int i, input bit rd, input bit a, input logic [7:0] d);
        @(posedge clk); #2;
        a9[i]   = a;
        hdin[i] = d;
        sel[i]  = 1'b1;
        if (rd) nre[i] = 1'b0;
        else    nwe[i] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        if (c_post && !rd) chk($sformatf("i%0d_iogt_posted", i), int'(iogt[i]), 1);
        wait_iogt_high(i);
        #2;
        sel[i] = 1'b0;
        nre[i] = 1'b1;
        nwe[i] = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        nRST = 1'b1;
        sel = '0; nre = '1; nwe = '1; a9 = '0; hdin = '0; edin = '0;
        #2 nRST = 1'b0;
        #1;
        // Reset values
        chk("rst_cs",    int'(cs_n[0]),  1);
        chk("rst_re",    int'(re_n[0]),  1);
        chk("rst_we",    int'(we_n[0]),  1);
        chk("rst_cmd",   int'(cmd[0]),   0);
        chk("rst_oe",    int'(doe[0]),   0);
        chk("rst_edout", int'(edout[0]), 0);
        chk("rst_hdout", int'(hdout[0]), 0);
        chk("rst_iogt",  int'(iogt[0]),  1);
        chk("rst_busy",  int'(busy[0]),  0);
        repeat (3) @(posedge clk);
        #2 nRST = 1'b1;
        repeat (3) @(posedge clk);

        // 1: default read
        edin[0] = 8'hA5;
        push(0, mk(1, 1, 5, 3, 1, 0, 5, 8'hA5));
        host_access(0, 1'b1, 1'b1, 8'h00);
        repeat (4) @(negedge clk);
        chk("cmd_holds_idle", int'(cmd[0]), 1);
        chk("hdout_holds",    int'(hdout[0]), 8'hA5);

        // Default-timing write
        push(0, mk(0, 0, 5, 3, 1, 5, c_post ? 0 : 5, 8'h96));
        host_access(0, 1'b0, 1'b0, 8'h96);
        repeat (4) @(negedge clk);
        chk("hdout_after_write", int'(hdout[0]), 8'hA5);

        // 2: write on the 2/4/2 instance
        push(1, mk(0, 0, 8, 4, 2, 8, c_post ? 0 : 8, 8'h3C));
        host_access(1, 1'b0, 1'b0, 8'h3C);
        repeat (4) @(posedge clk);

        // 3: host abort one clk after strobe entry
        edin[0] = 8'h5A;
        a9[0]   = 1'b1;
        push(0, mk(1, 1, 5, 3, 1, 0, 5, 8'h5A));
        @(posedge clk); #2;
        sel[0] = 1'b1; nre[0] = 1'b0;
        wait_re_low(0);
        @(posedge clk); #2;
        sel[0] = 1'b0; nre[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_idle_busy", int'(busy[0]), 0);
        chk("abort_idle_cs",   int'(cs_n[0]), 1);

        // 4: reset in the middle of the strobe
        edin[0] = 8'h77;
        @(posedge clk); #2;
        sel[0] = 1'b1; nre[0] = 1'b0;
        wait_re_low(0);
        @(posedge clk); #3;
        nRST = 1'b0;
        #1;
        chk("midrst_cs",    int'(cs_n[0]),  1);
        chk("midrst_re",    int'(re_n[0]),  1);
        chk("midrst_iogt",  int'(iogt[0]),  1);
        chk("midrst_busy",  int'(busy[0]),  0);
        chk("midrst_cmd",   int'(cmd[0]),   0);
        chk("midrst_hdout", int'(hdout[0]), 0);
        sel[0] = 1'b0; nre[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2 nRST = 1'b1;
        repeat (10) @(negedge clk);
        chk("postrst_idle", int'(busy[0]), 0);

        // 5a: both strobes low -> no access
        @(posedge clk); #2;
        sel[0] = 1'b1; nre[0] = 1'b0; nwe[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                chk("both_low_busy", int'(busy[0]), 0);
                chk("both_low_cs",   int'(cs_n[0]), 1);
                chk("both_low_iogt", int'(iogt[0]), 1);
            end
        end
        sel[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 nre[0] = 1'b1; nwe[0] = 1'b1;
        repeat (3) @(posedge clk);

        // 5b: back-to-back reads with sel held -> one chip cycle only
        edin[0] = 8'h42;
        a9[0]   = 1'b0;
        push(0, mk(0, 1, 5, 3, 1, 0, 5, 8'h42));
        @(posedge clk); #2;
        sel[0] = 1'b1; nre[0] = 1'b0;
        repeat (4) @(posedge clk);
        wait_iogt_high(0);
        #2 nre[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2 nre[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("b2b_in_done", int'(busy[0]), 1);
        chk("b2b_no_cs",   int'(cs_n[0]), 1);
        sel[0] = 1'b0; nre[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("b2b_back_idle", int'(busy[0]), 0);

        // 6: write then immediate read on the 2/4/2 instance
        edin[1] = 8'hC3;
        push(1, mk(1, 0, 8, 4, 2, 8, c_post ? -1 : 8, 8'h11));
        host_access(1, 1'b0, 1'b1, 8'h11);
        push(1, mk(0, 1, 8, 4, 2, 0, 8, 8'hC3));
        host_access(1, 1'b1, 1'b0, 8'h00);
        repeat (6) @(negedge clk);
        chk("final_hdout1", int'(hdout[1]), 8'hC3);
        chk("final_idle1",  int'(busy[1]),  0);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
